// File: rtl/fadd_pkg.sv
// rtl/fadd_pkg.sv - shared constants and FSM state type for the FP32 magnitude-add path
package fadd_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int EXT_W = 27;

    localparam logic [31:0]      QNAN    = 32'h7FC00000;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        ROUND = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/fadd_mag_add_seq_if.sv
// rtl/fadd_mag_add_seq_if.sv - operand/result handshake bundle for fadd_mag_add_seq
interface fadd_mag_add_seq_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        inexact;
    logic        overflow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, inexact, overflow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, inexact, overflow
    );

endinterface

// File: rtl/fadd_align_shifter.sv
// rtl/fadd_align_shifter.sv - right shift of an extended mantissa with sticky OR of the lost bits
module fadd_align_shifter
    import fadd_pkg::*;
(
    input  logic [EXT_W-1:0] i_data,
    input  logic [EXP_W-1:0] i_amt,
    output logic [EXT_W-1:0] o_data,
    output logic             o_sticky
);

    logic [EXT_W-1:0] w_mask;

    always_comb begin
        w_mask   = '1;
        o_data   = '0;
        o_sticky = 1'b0;
        if (i_amt >= EXP_W'(EXT_W)) begin
            o_sticky = |i_data;
        end else begin
            w_mask   = (EXT_W'(1) << i_amt) - EXT_W'(1);
            o_data   = i_data >> i_amt;
            o_sticky = |(i_data & w_mask);
        end
    end

endmodule

// File: rtl/fadd_mag_add_seq.sv
// rtl/fadd_mag_add_seq.sv - multi-cycle FP32 |a|+|b| with sign of a, round-to-nearest-even
module fadd_mag_add_seq
    import fadd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    fadd_mag_add_seq_if.slave bus
);

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [31:0]      r_result;
    logic             r_inexact;
    logic             r_overflow;

    logic             r_sa;
    logic             r_special;
    logic [31:0]      r_spec_res;
    logic [EXP_W-1:0] r_ea;
    logic [EXP_W-1:0] r_eb;
    logic [MAN_W:0]   r_ma;
    logic [MAN_W:0]   r_mb;
    logic [EXT_W-1:0] r_big;
    logic [EXT_W-1:0] r_small;
    logic [EXP_W:0]   r_exp;
    logic [EXT_W:0]   r_sum;
    logic [EXT_W-1:0] r_mant;

    logic [EXP_W-1:0] w_a_exp;
    logic [EXP_W-1:0] w_b_exp;
    logic [MAN_W-1:0] w_a_man;
    logic [MAN_W-1:0] w_b_man;
    logic             w_a_zero;
    logic             w_b_zero;
    logic             w_a_inf;
    logic             w_b_inf;
    logic             w_any_nan;
    logic             w_is_special;
    logic [31:0]      w_spec_res;
    logic             w_unused_sign_b;

    assign w_a_exp         = bus.a[30:23];
    assign w_b_exp         = bus.b[30:23];
    assign w_a_man         = bus.a[MAN_W-1:0];
    assign w_b_man         = bus.b[MAN_W-1:0];
    assign w_a_zero        = (w_a_exp == '0);
    assign w_b_zero        = (w_b_exp == '0);
    assign w_a_inf         = (w_a_exp == EXP_MAX) && (w_a_man == '0);
    assign w_b_inf         = (w_b_exp == EXP_MAX) && (w_b_man == '0);
    assign w_any_nan       = ((w_a_exp == EXP_MAX) && (w_a_man != '0)) ||
                             ((w_b_exp == EXP_MAX) && (w_b_man != '0));
    assign w_is_special    = w_any_nan || w_a_inf || w_b_inf || (w_a_zero && w_b_zero);
    assign w_unused_sign_b = bus.b[31];

    // NaN outranks infinity, which outranks the both-zero case.
    always_comb begin
        w_spec_res = {bus.a[31], 31'h0};
        if (w_any_nan) begin
            w_spec_res = QNAN;
        end else if (w_a_inf || w_b_inf) begin
            w_spec_res = {bus.a[31], EXP_MAX, {MAN_W{1'b0}}};
        end
    end

    logic             w_swap;
    logic [EXP_W-1:0] w_big_e;
    logic [EXP_W-1:0] w_small_e;
    logic [MAN_W:0]   w_big_m;
    logic [MAN_W:0]   w_small_m;
    logic [EXP_W-1:0] w_shamt;
    logic [EXT_W-1:0] w_sh_data;
    logic             w_sh_sticky;

    assign w_swap    = (r_eb > r_ea);
    assign w_big_e   = w_swap ? r_eb : r_ea;
    assign w_small_e = w_swap ? r_ea : r_eb;
    assign w_big_m   = w_swap ? r_mb : r_ma;
    assign w_small_m = w_swap ? r_ma : r_mb;
    assign w_shamt   = w_big_e - w_small_e;

    fadd_align_shifter u_align (
        .i_data   ({w_small_m, 3'b000}),
        .i_amt    (w_shamt),
        .o_data   (w_sh_data),
        .o_sticky (w_sh_sticky)
    );

    logic [EXT_W-1:0] w_norm_mant;
    logic [EXP_W:0]   w_norm_exp;

    assign w_norm_mant = r_sum[EXT_W] ? {r_sum[EXT_W:2], r_sum[1] | r_sum[0]} : r_sum[EXT_W-1:0];
    assign w_norm_exp  = r_sum[EXT_W] ? r_exp + 1'b1 : r_exp;

    logic             w_g;
    logic             w_r;
    logic             w_s;
    logic             w_l;
    logic             w_up;
    logic             w_inexact;
    logic [MAN_W+1:0] w_rnd;
    logic [MAN_W-1:0] w_fin_man;
    logic [EXP_W:0]   w_rnd_exp;

    assign w_l       = r_mant[3];
    assign w_g       = r_mant[2];
    assign w_r       = r_mant[1];
    assign w_s       = r_mant[0];
    assign w_up      = w_g && (w_r || w_s || w_l);
    assign w_inexact = w_g | w_r | w_s;
    assign w_rnd     = {1'b0, r_mant[EXT_W-1:3]} + (MAN_W+2)'(w_up);
    assign w_fin_man = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
    assign w_rnd_exp = w_rnd[MAN_W+1] ? r_exp + 1'b1 : r_exp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_inexact   <= 1'b0;
            r_overflow  <= 1'b0;
            r_sa        <= 1'b0;
            r_special   <= 1'b0;
            r_spec_res  <= '0;
            r_ea        <= '0;
            r_eb        <= '0;
            r_ma        <= '0;
            r_mb        <= '0;
            r_big       <= '0;
            r_small     <= '0;
            r_exp       <= '0;
            r_sum       <= '0;
            r_mant      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_sa       <= bus.a[31];
                        r_ea       <= w_a_exp;
                        r_eb       <= w_b_exp;
                        r_ma       <= w_a_zero ? '0 : {1'b1, w_a_man};
                        r_mb       <= w_b_zero ? '0 : {1'b1, w_b_man};
                        r_special  <= w_is_special;
                        r_spec_res <= w_spec_res;
                        r_in_ready <= 1'b0;
                        r_state    <= ALIGN;
                    end
                end
                ALIGN: begin
                    r_big   <= {w_big_m, 3'b000};
                    // Bits lost below S fold into S; big's low 3 bits are zero so this cannot carry.
                    r_small <= {w_sh_data[EXT_W-1:1], w_sh_data[0] | w_sh_sticky};
                    r_exp   <= {1'b0, w_big_e};
                    r_state <= ADD;
                end
                ADD: begin
                    r_sum   <= {1'b0, r_big} + {1'b0, r_small};
                    r_state <= NORM;
                end
                NORM: begin
                    r_mant  <= w_norm_mant;
                    r_exp   <= w_norm_exp;
                    r_state <= ROUND;
                end
                ROUND: begin
                    if (r_special) begin
                        r_result   <= r_spec_res;
                        r_inexact  <= 1'b0;
                        r_overflow <= 1'b0;
                    end else if (w_rnd_exp >= {1'b0, EXP_MAX}) begin
                        r_result   <= {r_sa, EXP_MAX, {MAN_W{1'b0}}};
                        r_inexact  <= w_inexact;
                        r_overflow <= 1'b1;
                    end else begin
                        r_result   <= {r_sa, w_rnd_exp[EXP_W-1:0], w_fin_man};
                        r_inexact  <= w_inexact;
                        r_overflow <= 1'b0;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.inexact   = r_inexact;
    assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_fadd_mag_add_seq.sv
// tb/tb_fadd_mag_add_seq.sv - self-checking bench for fadd_mag_add_seq
module tb_fadd_mag_add_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fadd_mag_add_seq_if bus ();

    fadd_mag_add_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        inex;
        logic        ovf;
    } vec_t;

    vec_t        vecs[14];
    logic [33:0] sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Independent reference: exact integer sum of the two significands, then RNE on the remainder.
    function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        longint unsigned ea, eb, ma, mb, t, d, s, q, rem, half, shift, ex;
        int p;
        logic inex;
        ea = 64'(a[30:23]);
        eb = 64'(b[30:23]);
        ma = 64'({1'b1, a[22:0]});
        mb = 64'({1'b1, b[22:0]});
        if (eb > ea) begin
            t = ea; ea = eb; eb = t;
            t = ma; ma = mb; mb = t;
        end
        d = ea - eb;
        if (d > 30) begin
            q = ma; ex = ea; inex = 1'b1;
        end else begin
            s = (ma << d) + mb;
            p = 63;
            while (s[p] == 1'b0) p--;
            shift = 64'(p - 23);
            q     = s >> shift;
            rem   = s & ((64'd1 << shift) - 64'd1);
            half  = (shift == 0) ? 64'd0 : (64'd1 << (shift - 1));
            inex  = (rem != 0);
            if (shift > 0 && (rem > half || (rem == half && q[0]))) q++;
            if (q[24]) begin
                q = q >> 1;
                shift++;
            end
            ex = eb + shift;
        end
        if (ex >= 255) return {a[31], 8'hFF, 23'h0, inex, 1'b1};
        return {a[31], ex[7:0], q[22:0], inex, 1'b0};
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [33:0] e);
        int n;
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck low");
        end
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(input string name);
        int n;
        logic [33:0] e;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        e = (sb.size() > 0) ? sb.pop_front() : 34'h0;
        check({name, "_latency"}, 64'(n), 64'd4);
        check({name, "_result"}, 64'({bus.result, bus.inexact, bus.overflow}), 64'(e));
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        logic [31:0] ra, rb;
        logic [7:0]  ea8, eb8;
        int          dd, eb_i;
        logic        sg;
        int          n;

        vecs[0]  = '{32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0};
        vecs[1]  = '{32'h3F800000, 32'h33800000, 32'h3F800000, 1'b1, 1'b0};
        vecs[2]  = '{32'h3F800001, 32'h33800000, 32'h3F800002, 1'b1, 1'b0};
        vecs[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b0, 1'b1};
        vecs[4]  = '{32'hBF800000, 32'h3F800000, 32'hC0000000, 1'b0, 1'b0};
        vecs[5]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0};
        vecs[6]  = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b0, 1'b0};
        vecs[7]  = '{32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
        vecs[8]  = '{32'h4F000000, 32'h3F800000, 32'h4F000000, 1'b1, 1'b0};
        vecs[9]  = '{32'h3F7FFFFF, 32'h33000000, 32'h3F800000, 1'b1, 1'b0};
        vecs[10] = '{32'h3F800000, 32'h00000000, 32'h3F800000, 1'b0, 1'b0};
        vecs[11] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 1'b0, 1'b0};
        vecs[12] = '{32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 1'b0};
        vecs[13] = '{32'h3F7FFFFF, 32'h33800000, 32'h3F800000, 1'b0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_result", 64'({bus.result, bus.inexact, bus.overflow}), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            send(vecs[i].a, vecs[i].b, {vecs[i].res, vecs[i].inex, vecs[i].ovf});
            collect($sformatf("vec%0d", i));
        end

        // Backpressure: result held for 3 cycles while a competing request is ignored.
        bus.out_ready = 1'b0;
        send(32'h3F800000, 32'h40000000, {32'h40400000, 1'b0, 1'b0});
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_latency", 64'(n), 64'd4);
        held = bus.result;
        for (int k = 0; k < 3; k++) begin
            bus.a        = 32'h40000000;
            bus.b        = 32'h40000000;
            bus.in_valid = 1'b1;
            @(negedge clk);
            check($sformatf("bp_hold_valid%0d", k), 64'(bus.out_valid), 64'd1);
            check($sformatf("bp_hold_result%0d", k), 64'(bus.result), 64'(held));
            check($sformatf("bp_in_ready%0d", k), 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        check("bp_result", 64'({bus.result, bus.inexact, bus.overflow}), 64'(sb.pop_front()));
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 64'(bus.out_valid), 64'd0);
        check("bp_release_ready", 64'(bus.in_ready), 64'd1);
        repeat (6) @(negedge clk);
        check("bp_no_ghost_op", 64'(bus.out_valid), 64'd0);

        // Reset while in ALIGN abandons the operation immediately.
        send(32'h3F800000, 32'h3F800000, {32'h40000000, 1'b0, 1'b0});
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_mid_result", 64'(bus.result), 64'd0);
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        send(32'h40000000, 32'h40000000, {32'h40800000, 1'b0, 1'b0});
        collect("post_reset");

        for (int i = 0; i < 60; i++) begin
            sg   = 1'($urandom_range(0, 1));
            ea8  = 8'($urandom_range(1, 254));
            dd   = (i % 4 == 0) ? int'($urandom_range(27, 60)) : int'($urandom_range(0, 26));
            eb_i = int'(ea8) - dd;
            if (eb_i < 1) eb_i = 1;
            eb8  = 8'(eb_i);
            ra   = {sg, ea8, 23'($urandom)};
            rb   = {sg, eb8, 23'($urandom)};
            if ($urandom_range(0, 1) == 1) begin
                held = ra; ra = rb; rb = held;
            end
            send(ra, rb, ref_add(ra, rb));
            collect($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
